// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage.
// Drives the pipeline-freeze busy signal and registers HI/LO on completion.
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startE,
    input  logic [1:0]        opE,
    input  logic [DATA_W-1:0] srcaE,
    input  logic [DATA_W-1:0] srcbE,
    input  logic              flushE,
    output logic              isMulOrDivComputingE,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              result_valid
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_dmag;
    logic                r_sgn;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_bz;

    logic                w_signed;
    logic [DATA_W-1:0]   w_amag;
    logic [DATA_W-1:0]   w_bmag;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_trial;
    logic                w_ge;
    logic [DATA_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]   w_quo_nxt;
    logic [DATA_W-1:0]   w_lo_div;
    logic [DATA_W-1:0]   w_hi_div;
    logic [2*DATA_W-1:0] w_ext_a;
    logic [2*DATA_W-1:0] w_ext_b;
    logic [2*DATA_W-1:0] w_prod;

    // Magnitudes are unsigned DATA_W, so the most-negative value needs no extra bit.
    assign w_signed = ~opE[0];
    assign w_amag   = (w_signed & srcaE[DATA_W-1]) ? -srcaE : srcaE;
    assign w_bmag   = (w_signed & srcbE[DATA_W-1]) ? -srcbE : srcbE;

    assign w_shift   = {r_rem, r_quo[DATA_W-1]};
    assign w_trial   = w_shift - {1'b0, r_dmag};
    assign w_ge      = ~w_trial[DATA_W];
    assign w_rem_nxt = w_ge ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_quo_nxt = {r_quo[DATA_W-2:0], w_ge};

    assign w_lo_div = r_bz ? '1  : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
    assign w_hi_div = r_bz ? r_a : (r_neg_r ? -w_rem_nxt : w_rem_nxt);

    assign w_ext_a = {{DATA_W{r_sgn & r_a[DATA_W-1]}}, r_a};
    assign w_ext_b = {{DATA_W{r_sgn & r_b[DATA_W-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign isMulOrDivComputingE = ~flushE & (((r_state == IDLE) & startE) |
                                             (r_state == MUL) | (r_state == DIV));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (startE & ~flushE) begin
                        r_a     <= srcaE;
                        r_b     <= srcbE;
                        r_sgn   <= w_signed;
                        r_quo   <= w_amag;
                        r_dmag  <= w_bmag;
                        r_rem   <= '0;
                        r_neg_q <= w_signed & (srcaE[DATA_W-1] ^ srcbE[DATA_W-1]);
                        r_neg_r <= w_signed & srcaE[DATA_W-1];
                        r_bz    <= (srcbE == '0);
                        r_cnt   <= '0;
                        r_state <= opE[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (flushE) begin
                        r_state <= IDLE;
                    end else begin
                        {hi_o, lo_o} <= w_prod;
                        result_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DIV: begin
                    if (flushE) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        // Last quotient bit is folded into the fixup so results land on entry to DONE.
                        if (r_cnt == CW'(DATA_W - 1)) begin
                            hi_o         <= w_hi_div;
                            lo_o         <= w_lo_div;
                            result_valid <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: per-cycle compare of busy, valid and HI/LO
// against an arithmetic model driven by directed and randomized instructions.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        result_valid;

    logic        chk_en = 1'b0;
    logic        exp_busy;
    logic        exp_valid;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          n_checks = 0;
    int          n_fail   = 0;

    mul_div_unit #(.DATA_W(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .startE               (startE),
        .opE                  (opE),
        .srcaE                (srcaE),
        .srcbE                (srcbE),
        .flushE               (flushE),
        .isMulOrDivComputingE (busy),
        .hi_o                 (hi_o),
        .lo_o                 (lo_o),
        .result_valid         (result_valid)
    );

    always #5 clk = ~clk;

    // Result of one instruction as {HI, LO}, straight from the arithmetic rules.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 2'b00) begin
            res = 64'(sa * sb);
        end else if (op == 2'b01) begin
            res = ua * ub;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b11) begin
            res = {a % b, a / b};
        end else begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",  {31'd0, busy},         {31'd0, exp_busy});
            chk("valid", {31'd0, result_valid}, {31'd0, exp_valid});
            chk("hi",    hi_o, exp_hi);
            chk("lo",    lo_o, exp_lo);
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        startE    = 1'b0;
        flushE    = 1'b0;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
    endtask

    // Presents one instruction; flush_c flushes on that cycle, abort_c stops before that cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_c, input int abort_c, input bit pin, input logic [63:0] lit);
        logic [63:0] r;
        int          lat;
        r   = model(op, a, b);
        lat = op[1] ? 33 : 2;
        if (pin) begin
            n_checks++;
            if (r !== lit) begin
                n_fail++;
                $display("FAIL model_pin actual=%0h required=%0h", r, lit);
            end
        end
        for (int c = 1; c <= lat + 1; c++) begin
            if (c == abort_c) break;
            @(posedge clk); #1;
            startE = 1'b1;
            opE    = op;
            srcaE  = (c == 1) ? a : $urandom;
            srcbE  = (c == 1) ? b : $urandom;
            if (c == flush_c) begin
                flushE    = 1'b1;
                exp_busy  = 1'b0;
                exp_valid = 1'b0;
                break;
            end
            flushE    = 1'b0;
            exp_busy  = (c <= lat);
            exp_valid = (c == lat + 1);
            if (c == lat + 1) {exp_hi, exp_lo} = r;
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          fc;

        rst = 1'b0; startE = 1'b0; flushE = 1'b0; opE = '0; srcaE = '0; srcbE = '0;
        exp_busy = 1'b0; exp_valid = 1'b0; exp_hi = '0; exp_lo = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle();

        run_op(2'b11, 32'd100, 32'd7, 0, 0, 1, {32'd2, 32'd14});
        idle();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, {32'h0, 32'h8000_0000});
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 1, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 1, {32'd1, 32'hFFFF_FFFE});
        idle();
        run_op(2'b11, 32'd55, 32'd0, 0, 0, 1, {32'd55, 32'hFFFF_FFFF});
        idle();

        run_op(2'b11, 32'd7, 32'd3, 0, 0, 1, {32'd1, 32'd2});
        idle();
        run_op(2'b10, 32'd1234, 32'd11, 14, 0, 0, '0);
        run_op(2'b01, 32'd3, 32'd4, 0, 0, 1, {32'd0, 32'd12});
        idle();

        run_op(2'b00, 32'd3, 32'd3, 1, 0, 0, '0);
        idle();
        idle();

        // Reset held for two edges while the divider sits at counter 10.
        run_op(2'b11, 32'd1000, 32'd3, 0, 12, 0, '0);
        @(posedge clk); #1;
        rst = 1'b0; startE = 1'b0; exp_busy = 1'b1; exp_valid = 1'b0;
        @(posedge clk); #1;
        exp_busy = 1'b0; exp_hi = '0; exp_lo = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle();

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = -a;
                default: ;
            endcase
            fc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, op[1] ? 33 : 2) : 0;
            run_op(op, a, b, fc, 0, 0, '0);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        idle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle MULT/MULTU/DIV/DIVU engine in the execute stage of the 5-stage MIPS pipeline. It produces the HI/LO results.
- It drives the execute-stage busy signal that the hazard unit uses to freeze the whole pipeline.
- It obeys the exception flush that the hazard unit also acts on.
- It is the producer side of the mul/div stall handshake.

Parameters:
DATA_W, 32, operand/result width; division iterations = DATA_W.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-low
startE  input  1  mul/div instruction present in E stage (held high while E is stalled)
opE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srcaE  input  DATA_W  rs operand (multiplicand / dividend)
srcbE  input  DATA_W  rt operand (multiplier / divisor)
flushE  input  1  exception flush of E stage (haveExceptionE)
isMulOrDivComputingE  output  1  busy; stalls pipeline while high
hi_o  output  DATA_W  HI result (product high half / remainder)
lo_o  output  DATA_W  LO result (product low half / quotient)
result_valid  output  1  one-cycle pulse when hi_o/lo_o update

Behaviour:
- Reset: when rst==0 at a clock edge:
  - state=IDLE, counter=0, hi_o=0, lo_o=0, result_valid=0.
  - Reset overrides any operation in progress, including mid-division.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If startE & ~flushE: latch operands and op, then go to MUL (op[1]==0) or DIV (op[1]==1). For DIV, counter loads 0.
  - Busy is high combinationally in this accept cycle, so the instruction stays in E.
- MUL (1 cycle):
  - Register the full 2*DATA_W product: signed for MULT, unsigned for MULTU. Go to DONE.
- DIV (DATA_W cycles):
  - Restoring radix-2 division on magnitudes; one quotient bit per cycle; counter 0..DATA_W-1.
  - After counter==DATA_W-1, go to DONE.
  - Signed fixup for DIV: quotient negated iff sign(a)^sign(b); remainder takes sign of dividend.
  - Divide by zero raises no exception. It completes with the same latency, with lo=all-ones and hi=srcaE (both DIV and DIVU).
- DONE:
  - hi_o/lo_o register the result; result_valid=1 for this cycle only; busy=0, so the pipeline advances.
  - startE is ignored here, because it is still high from the same instruction.
  - Next state is IDLE unconditionally.
- Busy equation: isMulOrDivComputingE = ~flushE & ((state==IDLE & startE) | state==MUL | state==DIV).
- Latency, counted in busy cycles including the accept cycle:
  - multiply: 2; DONE follows on the 3rd cycle.
  - divide: DATA_W+1 = 33; DONE on the 34th.
- Flush:
  - flushE high in any state forces busy low in that same cycle and state=IDLE at the next edge.
  - No result_valid; hi_o/lo_o keep their previous values.
  - flushE with startE in IDLE means no accept.
- hi_o/lo_o hold their last completed values until the next DONE. Operand changes on srcaE/srcbE after accept have no effect.
- Back-to-back ops: a second mul/div entering E the cycle after DONE is accepted from IDLE normally. There are no dead cycles beyond DONE.
- Arithmetic:
  - Two's complement magnitude of the most-negative value is handled as unsigned DATA_W (no overflow).
  - DIV of 0x80000000 by -1 gives lo=0x80000000, hi=0.

Test Plan:
- Reset: rst=0 for 2 cycles mid-DIV at counter 10 -> next cycle state IDLE, busy=0, hi_o=lo_o=0, no result_valid.
- DIVU 100/7: startE=1, op=11 -> busy high exactly 33 cycles; on cycle 34 result_valid=1, lo_o=14, hi_o=2.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- MULT -3*5 -> busy 2 cycles, then hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. MULTU 0xFFFFFFFF*2 -> hi_o=1, lo_o=0xFFFFFFFE.
- Divide by zero: DIVU 55/0 -> 33 busy cycles, lo_o=0xFFFFFFFF, hi_o=55, no other side effect.
- Flush: previous hi/lo = 1/2; start DIV, assert flushE at counter 12 -> busy drops that cycle, IDLE next, result_valid never pulses, hi_o=1, lo_o=2. Then MULTU 3*4 back-to-back -> lo_o=12 after 2 busy cycles.
